// File: rtl/step_clk_pkg.sv
// Shared constants for the single-step CPU clock generator:
// FSM state encoding and default timing parameters.
package step_clk_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_HIGH  = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;

   localparam int DEF_DEBOUNCE_CYCLES = 100000;
   localparam int DEF_PULSE_HIGH      = 8;
   localparam int DEF_RUN_DIV         = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// Step button synchroniser, debounce filter and
// single-cycle rise detector on the accepted level.
module btn_debounce
   import step_clk_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic resetn,
   input  logic btn,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          btn_s1;
   logic          btn_s2;
   logic          btn_stable;
   logic          btn_stable_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         btn_s1       <= 1'b0;
         btn_s2       <= 1'b0;
         btn_stable   <= 1'b0;
         btn_stable_d <= 1'b0;
         cnt          <= '0;
      end else begin
         btn_s1       <= btn;
         btn_s2       <= btn_s1;
         btn_stable_d <= btn_stable;
         // a new level must persist for the whole window
         if (btn_s2 != btn_stable) begin
            if (cnt == CNT_LAST) begin
               btn_stable <= btn_s2;
               cnt        <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise = btn_stable & ~btn_stable_d;

endmodule

// File: rtl/step_clk_gen.sv
// Single-step / free-run CPU clock generator with a
// fixed-width glitch-free pulse and an exported step count.
module step_clk_gen
   import step_clk_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PULSE_HIGH      = DEF_PULSE_HIGH,
   parameter int RUN_DIV         = DEF_RUN_DIV
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        btn_clk,
   input  logic        run_mode,
   output logic        cpu_clk,
   output logic [31:0] step_count,
   output logic        busy
);

   localparam int DW = $clog2(RUN_DIV);
   localparam int PW = $clog2(PULSE_HIGH) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(PULSE_HIGH - 1);

   logic          btn_rise;
   logic          run_s1;
   logic          run_s2;
   logic [DW-1:0] div_cnt;
   logic          run_tick;
   logic          trigger;
   logic [1:0]    state;
   logic [PW-1:0] pcnt;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb (
      .clk   (clk),
      .resetn(resetn),
      .btn   (btn_clk),
      .rise  (btn_rise)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         run_s1  <= 1'b0;
         run_s2  <= 1'b0;
         div_cnt <= '0;
      end else begin
         run_s1 <= run_mode;
         run_s2 <= run_s1;
         if (!run_s2 || run_tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 1'b1;
      end
   end

   assign run_tick = (div_cnt == DIV_LAST);
   assign trigger  = run_s2 ? run_tick : btn_rise;

   // triggers seen outside IDLE are dropped, not queued
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         pcnt       <= '0;
         cpu_clk    <= 1'b0;
         step_count <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (trigger) begin
                  state      <= ST_HIGH;
                  cpu_clk    <= 1'b1;
                  step_count <= step_count + 32'd1;
                  pcnt       <= '0;
               end
            end
            ST_HIGH: begin
               if (pcnt == P_LAST) begin
                  state   <= ST_GUARD;
                  cpu_clk <= 1'b0;
                  pcnt    <= '0;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            ST_GUARD: begin
               if (pcnt == P_LAST) begin
                  state <= ST_IDLE;
                  pcnt  <= '0;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               cpu_clk <= 1'b0;
               pcnt    <= '0;
            end
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_step_clk_gen.sv
// Directed bench for step_clk_gen with short debounce,
// pulse and run-divider settings.
module tb_step_clk_gen;

   logic        clk;
   logic        resetn;
   logic        btn_clk;
   logic        run_mode;
   logic        cpu_clk;
   logic [31:0] step_count;
   logic        busy;

   int total;
   int bad;
   int rises;

   step_clk_gen #(
      .DEBOUNCE_CYCLES(4),
      .PULSE_HIGH     (2),
      .RUN_DIV        (20)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .btn_clk   (btn_clk),
      .run_mode  (run_mode),
      .cpu_clk   (cpu_clk),
      .step_count(step_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial rises = 0;
   always @(posedge cpu_clk) rises = rises + 1;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp)
      else begin
         bad = bad + 1;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] bpat;
      bit         exp_clk;
      total    = 0;
      bad      = 0;
      resetn   = 1'b0;
      btn_clk  = 1'b1;
      run_mode = 1'b0;

      // reset with the button held
      step(3);
      chk("rst_cpu_clk", 32'(cpu_clk), 32'd0);
      chk("rst_count", step_count, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      step(6);
      chk("held_e5_low", 32'(cpu_clk), 32'd0);
      step(1);
      chk("held_e6_high", 32'(cpu_clk), 32'd1);
      chk("held_count", step_count, 32'd1);
      chk("held_busy", 32'(busy), 32'd1);
      step(1);
      chk("held_e7_high", 32'(cpu_clk), 32'd1);
      step(1);
      chk("held_e8_low", 32'(cpu_clk), 32'd0);
      chk("held_guard_busy", 32'(busy), 32'd1);
      step(2);
      chk("held_idle", 32'(busy), 32'd0);
      btn_clk = 1'b0;
      step(20);
      chk("release_count", step_count, 32'd1);
      chk("release_rises", 32'(rises), 32'd1);

      // clean press
      btn_clk = 1'b1;
      step(6);
      chk("clean_e5_low", 32'(cpu_clk), 32'd0);
      step(1);
      chk("clean_e6_high", 32'(cpu_clk), 32'd1);
      chk("clean_count", step_count, 32'd2);
      step(1);
      chk("clean_e7_high", 32'(cpu_clk), 32'd1);
      step(1);
      chk("clean_e8_low", 32'(cpu_clk), 32'd0);
      step(17);
      btn_clk = 1'b0;
      step(12);
      chk("clean_rel_count", step_count, 32'd2);

      // bounce 1,0,1,1,0,1 then hold high
      bpat = 6'b101101;
      for (int i = 0; i < 6; i++) begin
         btn_clk = bpat[5-i];
         step(1);
      end
      chk("bounce_e5_low", 32'(cpu_clk), 32'd0);
      step(5);
      chk("bounce_e10_low", 32'(cpu_clk), 32'd0);
      step(1);
      chk("bounce_e11_high", 32'(cpu_clk), 32'd1);
      chk("bounce_count", step_count, 32'd3);
      step(10);
      btn_clk = 1'b0;
      step(12);
      chk("bounce_rises", 32'(rises), 32'd3);

      // trigger during busy is dropped
      btn_clk = 1'b1;
      step(7);
      chk("rapid_first", 32'(cpu_clk), 32'd1);
      chk("rapid_count1", step_count, 32'd4);
      force dut.trigger = 1'b1;
      step(1);
      release dut.trigger;
      step(4);
      chk("rapid_dropped", step_count, 32'd4);
      chk("rapid_idle", 32'(busy), 32'd0);
      btn_clk = 1'b0;
      step(12);
      btn_clk = 1'b1;
      step(7);
      chk("rapid_second", 32'(cpu_clk), 32'd1);
      chk("rapid_count2", step_count, 32'd5);
      step(6);
      btn_clk = 1'b0;
      step(12);

      // free-run: rises after M21, M41, M61, M81, M101
      run_mode = 1'b1;
      for (int i = 0; i < 102; i++) begin
         btn_clk = ((i / 8) % 2) == 1;
         step(1);
         exp_clk = (i >= 21) && (((i - 21) % 20) < 2);
         chk($sformatf("run_m%0d", i), 32'(cpu_clk), 32'(exp_clk));
      end
      chk("run_count", step_count, 32'd10);
      btn_clk  = 1'b0;
      run_mode = 1'b0;
      step(1);
      chk("run_stop_high", 32'(cpu_clk), 32'd1);
      step(1);
      chk("run_stop_low", 32'(cpu_clk), 32'd0);
      step(40);
      chk("run_stop_count", step_count, 32'd10);
      chk("run_stop_rises", 32'(rises), 32'd10);

      // wrap of the step counter
      force dut.step_count = 32'hFFFF_FFFF;
      step(1);
      release dut.step_count;
      step(1);
      chk("wrap_preset", step_count, 32'hFFFF_FFFF);
      btn_clk = 1'b1;
      step(7);
      chk("wrap_pulse", 32'(cpu_clk), 32'd1);
      chk("wrap_count", step_count, 32'd0);

      // reset in the middle of HIGH
      step(1);
      chk("mid_high", 32'(cpu_clk), 32'd1);
      resetn = 1'b0;
      step(1);
      chk("mid_rst_clk", 32'(cpu_clk), 32'd0);
      chk("mid_rst_count", step_count, 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      btn_clk = 1'b0;
      resetn  = 1'b1;
      step(12);
      chk("post_rst_count", step_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
